// File: rtl/aes128_pkg.sv
// -----------------------------------------------------------------------------
// aes128_pkg
// Shared definitions for the AES-128 CTR stream sequencer.
//   - AES core mode encodings (ECB, CBC, CFB, OFB, CTR), 4 bits wide
//   - seq_state_t: state encoding of the sequencer FSM
// No ports (package).
// -----------------------------------------------------------------------------
package aes128_pkg;

    localparam logic [3:0] MODE_ECB = 4'd0;
    localparam logic [3:0] MODE_CBC = 4'd1;
    localparam logic [3:0] MODE_CFB = 4'd2;
    localparam logic [3:0] MODE_OFB = 4'd3;
    localparam logic [3:0] MODE_CTR = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_GAP       = 3'd5
    } seq_state_t;

endpackage

// File: rtl/aes128_ctr_inc.sv
// -----------------------------------------------------------------------------
// aes128_ctr_inc
// Combinational 128-bit counter-block increment. The all-ones block wraps
// to all-zeros (plain modulo 2^128 arithmetic).
// Ports:
//   value      in  128  current counter block
//   next_value out 128  value + 1 (mod 2^128)
// -----------------------------------------------------------------------------
module aes128_ctr_inc (
    input  logic [127:0] value,
    output logic [127:0] next_value
);

    assign next_value = value + 128'd1;

endmodule

// File: rtl/aes128_ctr_seq.sv
// -----------------------------------------------------------------------------
// aes128_ctr_seq
// Sequences a stream of 128-bit blocks through an external AES core in CTR
// mode, one block in flight at a time. Key, IV, direction and block count
// are captured on start; the counter advances after each delivered result.
//
// Parameters:
//   TIMEOUT_CYCLES  max WAIT_CORE cycles without a core_ready rise (watchdog)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, decrypt, key, iv,    stream request and its settings (sampled with
//   nblocks                     start; nblocks = 0 is an empty stream)
//   in_valid/in_ready/in_data   input block handshake
//   out_valid/out_ready/out_data result block handshake
//   busy, done, err             status; done/err are one-cycle pulses
//   core_*                      AES core control, data and result
//
// Build option:
//   AES128_CTR_SEQ_TIMEOUT_EN   enables the WAIT_CORE watchdog and err pulse;
//                               without it err is constant 0 and the core is
//                               waited for indefinitely.
// -----------------------------------------------------------------------------
module aes128_ctr_seq
    import aes128_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic [15:0]  nblocks,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         core_cipher_en,
    output logic         core_decipher_en,
    output logic         core_chain_en,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    output logic [127:0] core_init_vector,
    output logic [3:0]   core_mode,
    output logic [15:0]  core_segment_len,
    input  logic [127:0] core_data_out,
    input  logic         core_ready
);

    seq_state_t   state, next_state;
    logic         decrypt_q;
    logic [127:0] key_q;
    logic [127:0] ctr_q;
    logic [127:0] ctr_next;
    logic [127:0] block_q;
    logic [127:0] result_q;
    logic [15:0]  remaining_q;
    logic         ready_q;
    logic         chain_q;
    logic         fetch_hs;
    logic         drain_hs;
    logic         core_rise;
    logic         timeout_hit;

    aes128_ctr_inc u_ctr_inc (
        .value      (ctr_q),
        .next_value (ctr_next)
    );

    assign fetch_hs  = (state == ST_FETCH) && in_valid;
    assign drain_hs  = (state == ST_DRAIN) && out_ready;
    // The core signals completion by a rising edge; a level left high from
    // an earlier operation must not be mistaken for a fresh result.
    assign core_rise = core_ready && !ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        core_cipher_en   = 1'b0;
        core_decipher_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (nblocks == 16'd0) ? ST_GAP : ST_FETCH;
                end
            end
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_cipher_en   = !decrypt_q;
                core_decipher_en = decrypt_q;
                next_state       = ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
                if (core_rise) begin
                    next_state = ST_DRAIN;
                end else if (timeout_hit) begin
                    next_state = ST_GAP;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = (remaining_q == 16'd1) ? ST_GAP : ST_FETCH;
                end
            end
            ST_GAP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Stream context and datapath registers. chain_q is registered from
    // next_state so it rises together with the first LAUNCH and stays up
    // across the FETCH cycles between blocks until the stream ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decrypt_q   <= 1'b0;
            key_q       <= '0;
            ctr_q       <= '0;
            block_q     <= '0;
            result_q    <= '0;
            remaining_q <= '0;
            ready_q     <= 1'b0;
            chain_q     <= 1'b0;
        end else begin
            ready_q <= core_ready;
            if ((state == ST_IDLE) && start) begin
                decrypt_q   <= decrypt;
                key_q       <= key;
                ctr_q       <= iv;
                remaining_q <= nblocks;
            end
            if (fetch_hs) begin
                block_q <= in_data;
            end
            if ((state == ST_WAIT_CORE) && core_rise) begin
                result_q <= core_data_out;
            end
            if (drain_hs) begin
                ctr_q       <= ctr_next;
                remaining_q <= remaining_q - 16'd1;
            end
            if (next_state == ST_LAUNCH) begin
                chain_q <= 1'b1;
            end else if ((next_state == ST_GAP) || (next_state == ST_IDLE)) begin
                chain_q <= 1'b0;
            end
        end
    end

`ifdef AES128_CTR_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        abort_q;

    assign timeout_hit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT_CORE cycles of the current block. abort_q marks
    // a GAP entered by timeout so that it reports err instead of done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            if (state == ST_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT_CORE) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if ((state == ST_WAIT_CORE) && !core_rise && timeout_hit) begin
                abort_q <= 1'b1;
            end else if (state == ST_GAP) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign done = (state == ST_GAP) && !abort_q;
    assign err  = (state == ST_GAP) && abort_q;
`else
    assign timeout_hit = 1'b0;
    assign done        = (state == ST_GAP);
    // No watchdog in this build, so err can never fire; a negative timeout
    // is not a meaningful setting and this folds to a constant zero.
    assign err         = (TIMEOUT_CYCLES < 0);
`endif

    assign busy             = (state != ST_IDLE);
    assign out_data         = result_q;
    assign core_chain_en    = chain_q;
    assign core_data_in     = block_q;
    assign core_key         = key_q;
    assign core_init_vector = ctr_q;
    assign core_mode        = (state == ST_IDLE) ? MODE_ECB : MODE_CTR;
    assign core_segment_len = 16'd0;

endmodule

// File: tb/tb_aes128_ctr_seq.sv
// -----------------------------------------------------------------------------
// tb_aes128_ctr_seq
// Directed bench for aes128_ctr_seq. A small CTR core model answers each
// launch with data_in XOR keystream, where the keystream for the NIST
// SP800-38A counter blocks is pt XOR ct of the published vectors.
// Build option: AES128_CTR_SEQ_TIMEOUT_EN adds the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_aes128_ctr_seq;

    localparam logic [127:0] VEC_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] VEC_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         decrypt;
    logic [127:0] key;
    logic [127:0] iv;
    logic [15:0]  nblocks;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         done;
    logic         err;
    logic         core_cipher_en;
    logic         core_decipher_en;
    logic         core_chain_en;
    logic [127:0] core_data_in;
    logic [127:0] core_key;
    logic [127:0] core_init_vector;
    logic [3:0]   core_mode;
    logic [15:0]  core_segment_len;
    logic [127:0] core_data_out;
    logic         core_ready;

    int compared   = 0;
    int mismatched = 0;
    int enable_cnt = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;

    bit           core_auto = 1'b1;
    int           core_lat  = 3;
    logic [127:0] exp_key   = '0;
    bit           exp_dec   = 1'b0;
    logic [127:0] last_iv   = '0;
    logic [127:0] last_data = '0;

    logic [127:0] pt_tab [4];
    logic [127:0] ct_tab [4];
    logic [127:0] ks_tab [4];

    aes128_ctr_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .decrypt          (decrypt),
        .key              (key),
        .iv               (iv),
        .nblocks          (nblocks),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .core_cipher_en   (core_cipher_en),
        .core_decipher_en (core_decipher_en),
        .core_chain_en    (core_chain_en),
        .core_data_in     (core_data_in),
        .core_key         (core_key),
        .core_init_vector (core_init_vector),
        .core_mode        (core_mode),
        .core_segment_len (core_segment_len),
        .core_data_out    (core_data_out),
        .core_ready       (core_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] expected);
        compared++;
        if (got !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
        end
    endtask

    // Keystream of the reference core: known vectors near VEC_IV, otherwise
    // simply the inverted counter block.
    function automatic logic [127:0] ksOf(input logic [127:0] c);
        logic [127:0] d;
        d = c - VEC_IV;
        if (d < 128'd4) return ks_tab[d[1:0]];
        return ~c;
    endfunction

    // Event counters sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (core_cipher_en || core_decipher_en) enable_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    // Core model: checks the launch cycle and, when enabled, answers after
    // core_lat cycles with a one-cycle core_ready pulse.
    initial begin
        core_ready    = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            if (core_cipher_en || core_decipher_en) begin
                last_iv   = core_init_vector;
                last_data = core_data_in;
                checkOutput("launch_key", core_key, exp_key);
                checkOutput("launch_mode", 128'(core_mode), 128'd4);
                checkOutput("launch_seglen", 128'(core_segment_len), 128'd0);
                checkOutput("launch_chain", 128'(core_chain_en), 128'd1);
                checkOutput("launch_dir", 128'({core_cipher_en, core_decipher_en}),
                            128'({~exp_dec, exp_dec}));
                if (core_auto) begin
                    repeat (core_lat) @(negedge clk);
                    core_data_out = last_data ^ ksOf(last_iv);
                    core_ready    = 1'b1;
                    @(negedge clk);
                    core_ready    = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input bit dec, input logic [127:0] k,
                                 input logic [127:0] v, input logic [15:0] n);
        exp_key = k;
        exp_dec = dec;
        start   = 1'b1;
        decrypt = dec;
        key     = k;
        iv      = v;
        nblocks = n;
        @(negedge clk);
        start   = 1'b0;
        decrypt = ~dec;
        key     = ~k;
        iv      = ~v;
        checkOutput("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic feedBlock(input logic [127:0] d);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) checkOutput("in_ready_wait", 128'd0, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic drainBlock(input logic [127:0] expected, input int stall);
        int w;
        int en0;
        bit ok;
        w = 0;
        while (!out_valid && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) checkOutput("out_valid_wait", 128'd0, 128'd1);
        checkOutput("out_data", out_data, expected);
        if (stall > 0) begin
            en0 = enable_cnt;
            ok  = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (out_data !== expected || !out_valid || in_ready) ok = 1'b0;
            end
            checkOutput("stall_hold", 128'(ok), 128'd1);
            checkOutput("stall_no_enable", 128'(enable_cnt - en0), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // which: 0 = plaintext in / ciphertext out, 1 = reverse, 2 = synthetic.
    task automatic runStream(input bit dec, input logic [127:0] k,
                             input logic [127:0] v, input int n, input int which,
                             input int stall_blk, input bit glitch);
        int d0;
        d0 = done_cnt;
        applyStimulus(dec, k, v, 16'(n));
        for (int i = 0; i < n; i++) begin
            logic [127:0] din;
            logic [127:0] dexp;
            case (which)
                0:       begin din = pt_tab[i]; dexp = ct_tab[i]; end
                1:       begin din = ct_tab[i]; dexp = pt_tab[i]; end
                default: begin
                    din  = {4{32'(32'hC0DE0000 + i)}};
                    dexp = din ^ ~(v + 128'(i));
                end
            endcase
            feedBlock(din);
            if (glitch && i == 0) begin
                start   = 1'b1;
                nblocks = 16'd9;
                @(negedge clk);
                start   = 1'b0;
            end
            drainBlock(dexp, (i == stall_blk) ? 10 : 0);
            checkOutput("launch_iv", last_iv, v + 128'(i));
            checkOutput("launch_data", last_data, din);
            if (i != n - 1) checkOutput("chain_between", 128'({core_chain_en, in_ready}), 128'd3);
        end
        checkOutput("gap_state", 128'({done, busy, core_chain_en}), 128'b110);
        @(negedge clk);
        checkOutput("idle_after_gap", 128'({busy, done, core_chain_en}), 128'd0);
        checkOutput("done_count", 128'(done_cnt - d0), 128'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int en0;
        int d0;
        int w;

        pt_tab[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        pt_tab[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        pt_tab[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        pt_tab[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        ct_tab[0] = 128'h874d6191b620e3261bef6864990db6ce;
        ct_tab[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
        ct_tab[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
        ct_tab[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;
        for (int i = 0; i < 4; i++) ks_tab[i] = pt_tab[i] ^ ct_tab[i];

        rst_n     = 1'b1;
        start     = 1'b0;
        decrypt   = 1'b0;
        key       = '0;
        iv        = '0;
        nblocks   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_ctrl", 128'({busy, done, err, in_ready, out_valid,
                    core_cipher_en, core_decipher_en, core_chain_en}), 128'd0);
        checkOutput("reset_buses", 128'({|out_data, |core_data_in, |core_key,
                    |core_init_vector, |core_mode, |core_segment_len}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] encrypt SP800-38A vectors, stall on block 1");
        core_lat = 3;
        runStream(1'b0, VEC_KEY, VEC_IV, 4, 0, 1, 1'b0);

        $display("[TB] decrypt SP800-38A vectors");
        core_lat = 1;
        runStream(1'b1, VEC_KEY, VEC_IV, 4, 1, -1, 1'b0);

        $display("[TB] counter wrap from all-ones, start while busy");
        core_lat = 2;
        runStream(1'b0, ALT_KEY, {128{1'b1}}, 2, 2, -1, 1'b1);
        checkOutput("wrap_iv", last_iv, 128'h0);

        $display("[TB] empty stream");
        en0 = enable_cnt;
        d0  = done_cnt;
        applyStimulus(1'b0, ALT_KEY, 128'h1, 16'd0);
        checkOutput("empty_done", 128'(done), 128'd1);
        @(negedge clk);
        checkOutput("empty_idle", 128'({busy, done}), 128'd0);
        checkOutput("empty_no_enable", 128'(enable_cnt - en0), 128'd0);
        checkOutput("empty_done_count", 128'(done_cnt - d0), 128'd1);

        $display("[TB] core_ready held high needs a fresh edge");
        core_auto  = 1'b0;
        core_ready = 1'b1;
        applyStimulus(1'b1, ALT_KEY, 128'h5555, 16'd1);
        feedBlock(128'hdeadbeef_00112233_44556677_8899aabb);
        repeat (6) @(negedge clk);
        checkOutput("level_no_complete", 128'(out_valid), 128'd0);
        core_ready = 1'b0;
        @(negedge clk);
        core_data_out = 128'hdeadbeef_00112233_44556677_8899aabb ^ ~128'h5555;
        core_ready    = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        drainBlock(128'hdeadbeef_00112233_44556677_8899aabb ^ ~128'h5555, 0);
        checkOutput("level_gap", 128'({done, busy, core_chain_en}), 128'b110);
        @(negedge clk);

        $display("[TB] reset during WAIT_CORE");
        applyStimulus(1'b0, ALT_KEY, 128'h7777, 16'd1);
        feedBlock(128'h0123456789abcdef0123456789abcdef);
        @(negedge clk);
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 128'({busy, done, err, in_ready, out_valid,
                    core_cipher_en, core_decipher_en, core_chain_en}), 128'd0);
        checkOutput("midreset_buses", 128'({|out_data, |core_data_in, |core_key,
                    |core_init_vector, |core_mode, |core_segment_len}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_data_out = 128'h99;
        core_ready    = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_discard", 128'({out_valid, busy, |out_data}), 128'd0);
        checkOutput("reset_no_done", 128'(done_cnt - d0), 128'd0);

`ifdef AES128_CTR_SEQ_TIMEOUT_EN
        $display("[TB] watchdog timeout with core_ready stuck low");
        d0 = done_cnt;
        applyStimulus(1'b0, ALT_KEY, 128'h8888, 16'd1);
        feedBlock(128'h5a5a);
        w = 0;
        while (!err && w < 600) begin
            @(negedge clk);
            w++;
        end
        checkOutput("timeout_wait_cycles", 128'(w - 1), 128'd256);
        checkOutput("timeout_gap", 128'({err, done, busy, core_chain_en}), 128'b0010);
        @(negedge clk);
        checkOutput("timeout_idle", 128'({busy, err}), 128'd0);
        checkOutput("timeout_no_done", 128'(done_cnt - d0), 128'd0);
`else
        w = 0;
        checkOutput("err_never", 128'(err_cnt + w), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
